// File: rtl/xnor_popcount_accum_if.sv
// Handshake bundle between the XNOR array, the popcount accumulator and the
// next-layer consumer. The master drives tiles and takes results; the slave is the accumulator.
interface xnor_popcount_accum_if #(
    parameter int PARAM_IN_CNT  = 8,
    parameter int PARAM_CH_CNT  = 4,
    parameter int PARAM_ACC_BIT = 16
);
    logic [PARAM_IN_CNT-1:0][PARAM_CH_CNT-1:0] xnor_i;
    logic                                      in_valid;
    logic                                      in_ready;
    logic signed [PARAM_ACC_BIT-1:0]           threshold_i;
    logic signed [PARAM_ACC_BIT-1:0]           result_o;
    logic                                      bin_o;
    logic                                      out_valid;
    logic                                      out_ready;

    modport master (
        output xnor_i,
        output in_valid,
        output threshold_i,
        output out_ready,
        input  in_ready,
        input  result_o,
        input  bin_o,
        input  out_valid
    );

    modport slave (
        input  xnor_i,
        input  in_valid,
        input  threshold_i,
        input  out_ready,
        output in_ready,
        output result_o,
        output bin_o,
        output out_valid
    );
endinterface

// File: rtl/xnor_popcount_accum.sv
// Binarized FC accumulator: decodes XNOR bits as +/-2^channel, sums them over
// PARAM_BEATS tiles and emits the signed pre-activation plus its thresholded sign.
module xnor_popcount_accum #(
    parameter int PARAM_IN_CNT  = 8,
    parameter int PARAM_CH_CNT  = 4,
    parameter int PARAM_BEATS   = 4,
    parameter int PARAM_ACC_BIT = 16
) (
    input logic                 clk,
    input logic                 rst,
    xnor_popcount_accum_if.slave bus
);
    localparam int CNT_W = (PARAM_BEATS > 1) ? $clog2(PARAM_BEATS) : 1;
    localparam longint MAX_MAG =
        longint'(PARAM_BEATS) * longint'(PARAM_IN_CNT) * ((longint'(1) << PARAM_CH_CNT) - 1);
    localparam longint ACC_LIMIT = (longint'(1) << (PARAM_ACC_BIT - 1)) - 1;

    if (MAX_MAG > ACC_LIMIT) begin : g_width_check
        $error("PARAM_ACC_BIT cannot hold the full accumulation range");
    end

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t                          state, state_nxt;
    logic [CNT_W-1:0]                beat_cnt, beat_nxt;
    logic signed [PARAM_ACC_BIT-1:0] acc, acc_nxt;
    logic signed [PARAM_ACC_BIT-1:0] result, result_nxt;
    logic                            bin, bin_nxt;
    logic signed [PARAM_ACC_BIT-1:0] contrib;
    logic signed [PARAM_ACC_BIT-1:0] sum;
    logic                            accept;
    logic                            last_beat;

    always_comb begin
        int unsigned ones;
        int          term;
        ones    = 0;
        term    = 0;
        contrib = '0;
        for (int unsigned c = 0; c < PARAM_CH_CNT; c++) begin
            ones = 0;
            for (int unsigned e = 0; e < PARAM_IN_CNT; e++) begin
                ones = ones + {31'd0, bus.xnor_i[e][c]};
            end
            term    = (2 * int'(ones) - PARAM_IN_CNT) <<< c;
            contrib = contrib + PARAM_ACC_BIT'(term);
        end
    end

    assign sum       = acc + contrib;
    assign last_beat = (beat_cnt == CNT_W'(PARAM_BEATS - 1));
    assign accept    = bus.in_valid && bus.in_ready;

    // acc/beat_cnt are already zero whenever DONE is entered, so an accept in
    // DONE follows the same path as in ACCUM; with one beat per neuron the
    // "last beat" branch keeps the FSM in DONE for back-to-back results.
    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat_cnt;
        acc_nxt       = acc;
        result_nxt    = result;
        bin_nxt       = bin;
        bus.in_ready  = 1'b1;
        bus.out_valid = 1'b0;

        if (state == ST_DONE) begin
            bus.out_valid = 1'b1;
            bus.in_ready  = bus.out_ready;
        end

        if (accept) begin
            if (last_beat) begin
                result_nxt = sum;
                bin_nxt    = (sum >= bus.threshold_i);
                acc_nxt    = '0;
                beat_nxt   = '0;
                state_nxt  = ST_DONE;
            end else begin
                acc_nxt   = sum;
                beat_nxt  = beat_cnt + CNT_W'(1);
                state_nxt = ST_ACCUM;
            end
        end else if (state == ST_DONE && bus.out_ready) begin
            state_nxt = ST_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ACCUM;
            beat_cnt <= '0;
            acc      <= '0;
            result   <= '0;
            bin      <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            acc      <= acc_nxt;
            result   <= result_nxt;
            bin      <= bin_nxt;
        end
    end

    assign bus.result_o = result;
    assign bus.bin_o    = bin;
endmodule
